// File: rtl/bai1_pio_in.sv
// Avalon-MM parallel input port: synchronized pins, rising-edge capture with
// write-1-to-clear, and a maskable level interrupt.
module bai1_pio_in #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] rise, clr;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;
    assign rise  = sync2_q & ~prev_q;
    assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Clear is applied before the new edges are ORed in, so a coincident edge survives.
    assign edge_capture_d = (edge_capture_q & ~clr) | rise;
    assign irq_mask_d     = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irq_mask_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            prev_q         <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
        end else begin
            sync1_q        <= in_port;
            sync2_q        <= sync1_q;
            prev_q         <= sync2_q;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = 32'(sync2_q);
            2'd2:    readdata = 32'(irq_mask_q);
            2'd3:    readdata = 32'(edge_capture_q);
            default: readdata = '0;
        endcase
    end

    assign irq = |(edge_capture_q & irq_mask_q);

    // Upper write-data bits carry no meaning for narrow ports.
    if (WIDTH < 32) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^writedata[31:WIDTH];
    end

endmodule
